// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout, halt opcode default, fetch FSM states.
// Latency: none (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int INSTR_W = 16;

    // Instruction format: opcode | reg_a | reg_b | imm
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RA_HI  = 11;
    localparam int RA_LO  = 8;
    localparam int RB_HI  = 7;
    localparam int RB_LO  = 4;
    localparam int IMM_HI = 3;
    localparam int IMM_LO = 0;

    localparam logic [3:0] HALT_OPCODE_DEF = 4'hF;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        WAIT   = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter: branch load beats sequential increment, wraps modulo 2^ADDR_W.
// Latency: new value visible one cycle after load/inc.
// Backpressure: none; holds its value when neither load nor inc is asserted.
module program_counter #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc
);

    // Redirect has priority over the sequential step; overflow wraps silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= target;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, reads imem over req/ack, presents instructions to decode (FETCH_HALT_EN adds halt).
// Latency: request one cycle after FETCH, instruction valid the cycle after ack; peak one instruction per two cycles.
// Backpressure: stall at the ack cycle parks the word in HOLD (valid held) until stall drops; branch overrides stall.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int                ADDR_W      = 8,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [3:0]        HALT_OPCODE = HALT_OPCODE_DEF
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               halted
);

    fetch_state_t        state_q, state_d;
    logic                flush_q, flush_d;
    logic                req_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [INSTR_W-1:0]  instr_d;
    logic                vld_d;
    logic [ADDR_W-1:0]   pcout_d;
    logic                pc_load;
    logic                pc_inc;
    logic [ADDR_W-1:0]   pc;
    logic                ack_ok;

    assign ack_ok = imem_req & imem_ack;

`ifdef FETCH_HALT_EN
    logic halted_q, halted_d;
    logic halt_cap;
    logic halt_held;

    assign halt_cap  = (opcode_of(imem_rdata)  == HALT_OPCODE);
    assign halt_held = (opcode_of(instruction) == HALT_OPCODE);
    assign halted    = halted_q;
`else
    logic unused_halt_opcode;

    assign unused_halt_opcode = ^HALT_OPCODE;
    assign halted             = 1'b0;
`endif

    program_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk    (clk),
        .reset  (reset),
        .load   (pc_load),
        .inc    (pc_inc),
        .target (branch_target),
        .pc     (pc)
    );

    // Next-state and next-output decode; priority is branch, then ack, then stall.
    always_comb begin
        state_d = state_q;
        flush_d = flush_q;
        req_d   = imem_req;
        addr_d  = imem_addr;
        instr_d = instruction;
        vld_d   = instr_valid;
        pcout_d = pc_out;
        pc_load = 1'b0;
        pc_inc  = 1'b0;
`ifdef FETCH_HALT_EN
        halted_d = halted_q;
`endif
        case (state_q)
            FETCH: begin
                vld_d = 1'b0;
                if (branch_taken) begin
                    pc_load = 1'b1;
                    state_d = FETCH;
                end else begin
                    req_d   = 1'b1;
                    addr_d  = pc;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (branch_taken) begin
                    // Any response for the old address is now stale.
                    pc_load = 1'b1;
                    vld_d   = 1'b0;
                    if (ack_ok) begin
                        req_d   = 1'b0;
                        flush_d = 1'b0;
                        state_d = FETCH;
                    end else begin
                        flush_d = 1'b1;
                    end
                end else if (ack_ok) begin
                    req_d = 1'b0;
                    if (flush_q) begin
                        flush_d = 1'b0;
                        state_d = FETCH;
                    end else begin
                        instr_d = imem_rdata;
                        pcout_d = imem_addr;
                        vld_d   = 1'b1;
                        pc_inc  = 1'b1;
                        if (stall) begin
                            state_d = HOLD;
`ifdef FETCH_HALT_EN
                        end else if (halt_cap) begin
                            state_d  = HALTED;
                            halted_d = 1'b1;
`endif
                        end else begin
                            state_d = FETCH;
                        end
                    end
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    pc_load = 1'b1;
                    vld_d   = 1'b0;
                    state_d = FETCH;
                end else if (!stall) begin
                    vld_d = 1'b0;
`ifdef FETCH_HALT_EN
                    if (halt_held) begin
                        state_d  = HALTED;
                        halted_d = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
`else
                    state_d = FETCH;
`endif
                end
            end
`ifdef FETCH_HALT_EN
            HALTED: begin
                req_d = 1'b0;
                vld_d = 1'b0;
                if (branch_taken) begin
                    pc_load  = 1'b1;
                    halted_d = 1'b0;
                    state_d  = FETCH;
                end
            end
`endif
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Register every output and the FSM state; reset abandons any in-flight request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            flush_q     <= 1'b0;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            instruction <= '0;
            instr_valid <= 1'b0;
            pc_out      <= '0;
        end else begin
            state_q     <= state_d;
            flush_q     <= flush_d;
            imem_req    <= req_d;
            imem_addr   <= addr_d;
            instruction <= instr_d;
            instr_valid <= vld_d;
            pc_out      <= pcout_d;
        end
    end

`ifdef FETCH_HALT_EN
    // Halt flag register, cleared only by reset or a redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed handshake/stall/branch/reset/halt steps, then random traffic vs a stream model.
// Latency: n/a.
// Backpressure: memory ack delay is address-driven in directed steps and random in the random phase.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_target = 8'h00;
    logic [15:0] instruction;
    logic        instr_valid;
    logic [7:0]  pc_out;
    logic        halted;

    // Memory model knobs
    logic rand_mode = 1'b0;
    logic ack_coin  = 1'b0;
    logic halt_pat  = 1'b0;
    int   wc = 0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instruction_fetch #(
        .ADDR_W   (8),
        .RESET_PC (8'hFE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instruction   (instruction),
        .instr_valid   (instr_valid),
        .pc_out        (pc_out),
        .halted        (halted)
    );

    function automatic int slow_delay(input logic [7:0] a);
        return (a == 8'h05 || a == 8'h07 || a == 8'h41) ? 3 : 0;
    endfunction

    function automatic logic [15:0] mem_word(input logic [7:0] a, input logic hp);
        return (hp && a == 8'h03) ? 16'hF000 : (16'hA000 | {8'h00, a});
    endfunction

    assign imem_ack   = imem_req && (rand_mode ? ack_coin : (wc >= slow_delay(imem_addr)));
    assign imem_rdata = mem_word(imem_addr, halt_pat);

    // Count cycles the current request has been outstanding.
    always @(posedge clk) begin
        if (!imem_req || imem_ack) wc <= 0;
        else                       wc <= wc + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0]  a;
        logic [7:0]  last;
        logic [7:0]  tgt;
        logic [7:0]  exp_pc;
        logic        has_br;
        logic        br;
        logic        p_req, p_ack, p_vld;
        logic [7:0]  p_addr, p_pcout;
        logic [15:0] p_instr;
        int          n_deliv;

        // Reset state
        step(); step();
        chk("rst_req", {15'd0, imem_req}, 16'd0);
        chk("rst_addr", {8'd0, imem_addr}, 16'd0);
        chk("rst_instr", instruction, 16'h0000);
        chk("rst_vld", {15'd0, instr_valid}, 16'd0);
        chk("rst_pcout", {8'd0, pc_out}, 16'd0);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        reset = 1'b0;

        // Same-cycle ack from RESET_PC=FE: FE, FF, wrap to 00, 01, 02
        for (int i = 0; i < 5; i++) begin
            a = 8'hFE + 8'(i);
            step();
            chk("seq_req", {15'd0, imem_req}, 16'd1);
            chk("seq_addr", {8'd0, imem_addr}, {8'd0, a});
            chk("seq_vld_lo", {15'd0, instr_valid}, 16'd0);
            step();
            chk("seq_vld", {15'd0, instr_valid}, 16'd1);
            chk("seq_instr", instruction, 16'hA000 | {8'd0, a});
            chk("seq_pcout", {8'd0, pc_out}, {8'd0, a});
            chk("seq_req_lo", {15'd0, imem_req}, 16'd0);
        end

        // Branch in FETCH back to 2, then stall at the ack of addr 2
        branch_taken = 1'b1; branch_target = 8'h02;
        step();
        chk("brf_req", {15'd0, imem_req}, 16'd0);
        chk("brf_vld", {15'd0, instr_valid}, 16'd0);
        branch_taken = 1'b0;
        stall = 1'b1;
        step();
        chk("stl_noeff_req", {15'd0, imem_req}, 16'd1);
        chk("stl_noeff_addr", {8'd0, imem_addr}, 16'h0002);
        step();
        chk("stl_vld", {15'd0, instr_valid}, 16'd1);
        chk("stl_instr", instruction, 16'hA002);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_vld", {15'd0, instr_valid}, 16'd1);
            chk("hold_instr", instruction, 16'hA002);
            chk("hold_pcout", {8'd0, pc_out}, 16'h0002);
            chk("hold_req", {15'd0, imem_req}, 16'd0);
        end
        stall = 1'b0;
        step();
        chk("unstl_vld", {15'd0, instr_valid}, 16'd0);
        chk("unstl_req", {15'd0, imem_req}, 16'd0);
        step();
        chk("after_stl_req", {15'd0, imem_req}, 16'd1);
        chk("after_stl_addr", {8'd0, imem_addr}, 16'h0003);
        step();
        chk("a3_instr", instruction, 16'hA003);
        step(); step();
        chk("a4_instr", instruction, 16'hA004);

        // Ack delayed 3 cycles at addr 5
        for (int i = 0; i < 4; i++) begin
            step();
            chk("slow_req", {15'd0, imem_req}, 16'd1);
            chk("slow_addr", {8'd0, imem_addr}, 16'h0005);
            chk("slow_vld", {15'd0, instr_valid}, 16'd0);
        end
        step();
        chk("slow_cap_vld", {15'd0, instr_valid}, 16'd1);
        chk("slow_cap_instr", instruction, 16'hA005);
        chk("slow_cap_pcout", {8'd0, pc_out}, 16'h0005);
        step();
        chk("slow_once_vld", {15'd0, instr_valid}, 16'd0);
        chk("next_addr6", {8'd0, imem_addr}, 16'h0006);

        // Branch to 40 while waiting on addr 7
        step();
        chk("a6_pcout", {8'd0, pc_out}, 16'h0006);
        step();
        chk("a7_addr", {8'd0, imem_addr}, 16'h0007);
        branch_taken = 1'b1; branch_target = 8'h40;
        step();
        branch_taken = 1'b0;
        chk("brw_req", {15'd0, imem_req}, 16'd1);
        chk("brw_addr", {8'd0, imem_addr}, 16'h0007);
        chk("brw_vld", {15'd0, instr_valid}, 16'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("flush_wait_addr", {8'd0, imem_addr}, 16'h0007);
            chk("flush_wait_vld", {15'd0, instr_valid}, 16'd0);
        end
        step();
        chk("flush_drop_vld", {15'd0, instr_valid}, 16'd0);
        chk("flush_drop_req", {15'd0, imem_req}, 16'd0);
        step();
        chk("br40_addr", {8'd0, imem_addr}, 16'h0040);
        step();
        chk("br40_vld", {15'd0, instr_valid}, 16'd1);
        chk("br40_pcout", {8'd0, pc_out}, 16'h0040);
        chk("br40_instr", instruction, 16'hA040);

        // Reset while waiting on addr 41
        step();
        chk("a41_addr", {8'd0, imem_addr}, 16'h0041);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_req", {15'd0, imem_req}, 16'd0);
        chk("midrst_instr", instruction, 16'h0000);
        step();
        chk("midrst_refetch", {8'd0, imem_addr}, 16'h00FE);

        // Branch with same-cycle ack drops the data, then fetch a halt opcode at 3
        halt_pat = 1'b1;
        branch_taken = 1'b1; branch_target = 8'h03;
        step();
        branch_taken = 1'b0;
        chk("brack_vld", {15'd0, instr_valid}, 16'd0);
        chk("brack_req", {15'd0, imem_req}, 16'd0);
        step();
        chk("h_addr", {8'd0, imem_addr}, 16'h0003);
        step();
        chk("h_vld", {15'd0, instr_valid}, 16'd1);
        chk("h_instr", instruction, 16'hF000);
        chk("h_pcout", {8'd0, pc_out}, 16'h0003);
`ifdef FETCH_HALT_EN
        chk("h_halted", {15'd0, halted}, 16'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("h_noreq", {15'd0, imem_req}, 16'd0);
            chk("h_novld", {15'd0, instr_valid}, 16'd0);
            chk("h_stay", {15'd0, halted}, 16'd1);
        end
        branch_taken = 1'b1; branch_target = 8'h10;
        step();
        branch_taken = 1'b0;
        chk("h_exit", {15'd0, halted}, 16'd0);
        step();
        chk("h_resume_addr", {8'd0, imem_addr}, 16'h0010);
        step();
        chk("h_resume_instr", instruction, 16'hA010);
`else
        chk("noh_halted", {15'd0, halted}, 16'd0);
        step();
        chk("noh_req", {15'd0, imem_req}, 16'd1);
        chk("noh_addr", {8'd0, imem_addr}, 16'h0004);
        step();
        chk("noh_instr", instruction, 16'hA004);
        chk("noh_pcout", {8'd0, pc_out}, 16'h0004);
`endif
        halt_pat = 1'b0;

        // Random traffic: delivered stream must follow last+1, or the latest branch target
        rand_mode = 1'b1;
        has_br = 1'b0; last = 8'h00; tgt = 8'h00; n_deliv = 0;
        for (int i = 0; i < 800; i++) begin
            br            = (i == 0) || ($urandom_range(0, 99) < 8);
            branch_taken  = br;
            branch_target = 8'($urandom);
            stall         = ($urandom_range(0, 99) < 30);
            ack_coin      = 1'($urandom_range(0, 1));
            #0;
            p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
            p_vld = instr_valid; p_instr = instruction; p_pcout = pc_out;
            step();
            if (p_req && !p_ack) begin
                chk("r_req_held", {15'd0, imem_req}, 16'd1);
                chk("r_addr_stable", {8'd0, imem_addr}, {8'd0, p_addr});
            end
            if (p_vld && instr_valid) begin
                chk("r_hold_instr", instruction, p_instr);
                chk("r_hold_pcout", {8'd0, pc_out}, {8'd0, p_pcout});
            end
            if (instr_valid && !p_vld) begin
                exp_pc = has_br ? tgt : last + 8'd1;
                chk("r_pcout", {8'd0, pc_out}, {8'd0, exp_pc});
                chk("r_instr", instruction, 16'hA000 | {8'd0, exp_pc});
                last   = exp_pc;
                has_br = 1'b0;
                n_deliv++;
            end
            if (br) begin
                has_br = 1'b1;
                tgt    = branch_target;
            end
            chk("r_halted", {15'd0, halted}, 16'd0);
        end
        branch_taken = 1'b0;
        stall = 1'b0;
        chk("r_deliveries", {15'd0, (n_deliv > 20)}, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
